// File: rtl/defs_pkg.sv
// Shared processor constants and helpers used by the pipeline stage registers.
// BIN_DIG is the instruction/data word width; NOP_INSN is the canonical bubble.
package defs;

    localparam int          BIN_DIG  = 32;
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;  // addi x0, x0, 0
    localparam int          DROP_W   = 8;

    // Per-cycle buffer activity, encoded as {push, pop}.
    typedef enum logic [1:0] {
        XFER_IDLE = 2'b00,
        XFER_POP  = 2'b01,
        XFER_PUSH = 2'b10,
        XFER_BOTH = 2'b11
    } xfer_e;

    function automatic logic [DROP_W-1:0] drop_sat_add(
        input logic [DROP_W-1:0] acc,
        input logic [DROP_W-1:0] inc
    );
        logic [DROP_W:0] sum;
        sum = {1'b0, acc} + {1'b0, inc};
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/pipe_stage_regs.sv
// Fetch/decode and decode/exec stage registers built from elastic buffers;
// a control hazard flushes both stages in the same cycle.
module pipe_stage_regs
    import defs::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               ctrl_hazard,
    input  logic               fetch_valid,
    input  logic [BIN_DIG-1:0] fetch_insn,
    output logic               fetch_ready,
    output logic               dec_valid,
    output logic [BIN_DIG-1:0] dec_insn,
    output logic               exec_valid,
    output logic [BIN_DIG-1:0] exec_insn,
    input  logic               exec_ready,
    output logic [1:0]         if_id_count,
    output logic [1:0]         id_ex_count,
    output logic [DROP_W-1:0]  if_id_drops,
    output logic [DROP_W-1:0]  id_ex_drops
);

    logic dec_ready;

    pipe_elastic_reg #(
        .WIDTH     (BIN_DIG),
        .DEPTH     (2),
        .NOP_VALUE (NOP_INSN)
    ) u_if_id (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (ctrl_hazard),
        .in_valid  (fetch_valid),
        .in_data   (fetch_insn),
        .in_ready  (fetch_ready),
        .out_valid (dec_valid),
        .out_data  (dec_insn),
        .out_ready (dec_ready),
        .count     (if_id_count),
        .drop_cnt  (if_id_drops)
    );

    pipe_elastic_reg #(
        .WIDTH     (BIN_DIG),
        .DEPTH     (2),
        .NOP_VALUE (NOP_INSN)
    ) u_id_ex (
        .CLK       (CLK),
        .RST       (RST),
        .flush     (ctrl_hazard),
        .in_valid  (dec_valid),
        .in_data   (dec_insn),
        .in_ready  (dec_ready),
        .out_valid (exec_valid),
        .out_data  (exec_insn),
        .out_ready (exec_ready),
        .count     (id_ex_count),
        .drop_cnt  (id_ex_drops)
    );

endmodule

// File: rtl/pipe_elastic_reg.sv
// Elastic pipeline register: a small circular buffer with valid/ready on both sides,
// a flush that drops everything in flight, and a saturating count of dropped entries.
module pipe_elastic_reg
    import defs::*;
#(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 2,
    parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(NOP_INSN)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DROP_W-1:0]          drop_cnt
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic [DROP_W-1:0] drop_q;

    logic              push;
    logic              pop;
    logic              in_taken;
    logic [DROP_W-1:0] drop_inc;
    xfer_e             xfer;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // in_ready looks only at occupancy, so a full buffer waits one cycle after a pop.
    assign in_ready  = (count_q < CNT_W'(DEPTH)) && !RST;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : NOP_VALUE;
    assign count     = count_q;
    assign drop_cnt  = drop_q;

    assign in_taken  = in_valid && in_ready;
    assign push      = in_taken && !flush;
    assign pop       = out_valid && out_ready && !flush;
    assign drop_inc  = DROP_W'(count_q) + DROP_W'(in_taken);

    always_comb begin
        xfer = XFER_IDLE;
        case ({push, pop})
            2'b01:   xfer = XFER_POP;
            2'b10:   xfer = XFER_PUSH;
            2'b11:   xfer = XFER_BOTH;
            default: xfer = XFER_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drop_q  <= '0;
        end else if (flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            drop_q  <= drop_sat_add(drop_q, drop_inc);
        end else begin
            case (xfer)
                XFER_PUSH: begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    count_q <= count_q + CNT_W'(1);
                end
                XFER_POP: begin
                    rd_ptr  <= ptr_inc(rd_ptr);
                    count_q <= count_q - CNT_W'(1);
                end
                XFER_BOTH: begin
                    wr_ptr  <= ptr_inc(wr_ptr);
                    rd_ptr  <= ptr_inc(rd_ptr);
                end
                default: ;
            endcase
        end
    end

    // NOTE: payload storage has no reset; out_data is masked to NOP_VALUE while empty,
    // so stale entries are never observable.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Self-checking bench: DEPTH=2 and DEPTH=3 instances against a queue model,
// plus directed literal checks and a smoke test of the two-stage wrapper.
module tb_pipe_elastic_reg;
    import defs::*;

    localparam logic [31:0] NOP = 32'h13;

    logic        CLK = 1'b0;
    logic        rst   [2];
    logic        flush [2];
    logic        iv    [2];
    logic        ordy  [2];
    logic [31:0] id    [2];
    logic        o_valid [2];
    logic        o_ready [2];
    logic [31:0] o_data  [2];
    logic [1:0]  o_cnt   [2];
    logic [7:0]  o_drop  [2];

    logic [31:0] mq [2][$];
    int          mdrop [2];
    logic        chk_en = 1'b0;
    int          n_chk = 0;
    int          n_err = 0;

    // Stage wrapper signals
    logic        sp_rst, sp_hz, sp_fv, sp_fr, sp_dv, sp_ev, sp_er;
    logic [31:0] sp_fi, sp_di, sp_ei;
    logic [1:0]  sp_c0, sp_c1;
    logic [7:0]  sp_d0, sp_d1;

    always #5 CLK = ~CLK;

    pipe_elastic_reg #(.WIDTH(32), .DEPTH(2)) dut2 (
        .CLK(CLK), .RST(rst[0]), .flush(flush[0]),
        .in_valid(iv[0]), .in_data(id[0]), .in_ready(o_ready[0]),
        .out_valid(o_valid[0]), .out_data(o_data[0]), .out_ready(ordy[0]),
        .count(o_cnt[0]), .drop_cnt(o_drop[0])
    );

    pipe_elastic_reg #(.WIDTH(32), .DEPTH(3)) dut3 (
        .CLK(CLK), .RST(rst[1]), .flush(flush[1]),
        .in_valid(iv[1]), .in_data(id[1]), .in_ready(o_ready[1]),
        .out_valid(o_valid[1]), .out_data(o_data[1]), .out_ready(ordy[1]),
        .count(o_cnt[1]), .drop_cnt(o_drop[1])
    );

    pipe_stage_regs u_stages (
        .CLK(CLK), .RST(sp_rst), .ctrl_hazard(sp_hz),
        .fetch_valid(sp_fv), .fetch_insn(sp_fi), .fetch_ready(sp_fr),
        .dec_valid(sp_dv), .dec_insn(sp_di),
        .exec_valid(sp_ev), .exec_insn(sp_ei), .exec_ready(sp_er),
        .if_id_count(sp_c0), .id_ex_count(sp_c1),
        .if_id_drops(sp_d0), .id_ex_drops(sp_d1)
    );

    function automatic int dep(input int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    // Behavioural model: a queue per instance, updated from the pre-edge inputs.
    always @(posedge CLK) begin
        for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
                mq[i].delete();
                mdrop[i] = 0;
            end else if (flush[i]) begin
                mdrop[i] = mdrop[i] + mq[i].size() + ((iv[i] && mq[i].size() < dep(i)) ? 1 : 0);
                if (mdrop[i] > 255) mdrop[i] = 255;
                mq[i].delete();
            end else begin
                automatic bit can_push = iv[i] && (mq[i].size() < dep(i));
                if (mq[i].size() != 0 && ordy[i]) void'(mq[i].pop_front());
                if (can_push) mq[i].push_back(id[i]);
            end
        end
    end

    // Every-cycle compare against the model.
    always @(negedge CLK) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                automatic int n = mq[i].size();
                check($sformatf("d%0d out_valid", i), 32'(o_valid[i]), 32'(n != 0));
                check($sformatf("d%0d out_data", i), o_data[i], (n != 0) ? mq[i][0] : NOP);
                check($sformatf("d%0d count", i), 32'(o_cnt[i]), 32'(n));
                check($sformatf("d%0d in_ready", i), 32'(o_ready[i]), 32'((n < dep(i)) && !rst[i]));
                check($sformatf("d%0d drop_cnt", i), 32'(o_drop[i]), 32'(mdrop[i]));
            end
        end
    end

    initial begin
        logic [31:0] captured [$];
        int          k;
        int          cycles;
        int          max_cnt;
        bit          accepted;

        rst = '{1'b1, 1'b1}; flush = '{1'b0, 1'b0};
        iv = '{1'b0, 1'b0}; ordy = '{1'b0, 1'b0}; id = '{32'h0, 32'h0};
        sp_rst = 1'b1; sp_hz = 1'b0; sp_fv = 1'b0; sp_fi = 32'h0; sp_er = 1'b0;
        @(posedge CLK);
        chk_en = 1'b1;
        cyc(); cyc();

        // Reset state
        check("rst out_valid", 32'(o_valid[0]), 32'h0);
        check("rst out_data", o_data[0], NOP);
        check("rst in_ready", 32'(o_ready[0]), 32'h0);
        check("rst count", 32'(o_cnt[0]), 32'h0);
        check("rst drop_cnt", 32'(o_drop[0]), 32'h0);
        rst = '{1'b0, 1'b0}; sp_rst = 1'b0;
        #1;
        check("post-rst in_ready d2", 32'(o_ready[0]), 32'h1);
        check("post-rst in_ready d3", 32'(o_ready[1]), 32'h1);

        // Stage wrapper: instruction walks fetch->decode->exec, hazard flushes it
        sp_fv = 1'b1; sp_fi = 32'h00A0_0093; sp_er = 1'b1;
        cyc();
        check("stg dec_valid", 32'(sp_dv), 32'h1);
        check("stg dec_insn", sp_di, 32'h00A0_0093);
        sp_fv = 1'b0;
        cyc();
        check("stg exec_insn", sp_ei, 32'h00A0_0093);
        check("stg dec_empty", 32'(sp_dv), 32'h0);
        sp_er = 1'b0; sp_hz = 1'b1;
        cyc();
        sp_hz = 1'b0;
        check("stg exec_valid flushed", 32'(sp_ev), 32'h0);
        check("stg exec_insn nop", sp_ei, NOP);
        check("stg id_ex_drops", 32'(sp_d1), 32'h1);

        // Back-to-back flow, DEPTH=2
        ordy[0] = 1'b1; iv[0] = 1'b1; id[0] = 32'hA;
        cyc();
        check("flow A", o_data[0], 32'hA); check("flow cnt A", 32'(o_cnt[0]), 32'h1);
        id[0] = 32'hB;
        cyc();
        check("flow B", o_data[0], 32'hB); check("flow cnt B", 32'(o_cnt[0]), 32'h1);
        id[0] = 32'hC;
        cyc();
        check("flow C", o_data[0], 32'hC); check("flow cnt C", 32'(o_cnt[0]), 32'h1);
        iv[0] = 1'b0;
        cyc();
        check("flow drained", o_data[0], NOP);

        // Backpressure, DEPTH=2
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h1;
        cyc();
        id[0] = 32'h2;
        cyc();
        check("bp full cnt", 32'(o_cnt[0]), 32'h2);
        check("bp full in_ready", 32'(o_ready[0]), 32'h0);
        id[0] = 32'h3;
        cyc();
        check("bp refuse cnt", 32'(o_cnt[0]), 32'h2);
        check("bp head", o_data[0], 32'h1);
        ordy[0] = 1'b1;
        cyc();
        check("bp pop1 next", o_data[0], 32'h2);
        check("bp pop1 cnt", 32'(o_cnt[0]), 32'h1);
        check("bp in_ready back", 32'(o_ready[0]), 32'h1);
        iv[0] = 1'b0;
        cyc();
        check("bp drained", 32'(o_valid[0]), 32'h0);

        // Reset with count=2 and flush together: no drops recorded
        ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'h21;
        cyc();
        id[0] = 32'h22;
        cyc();
        check("rstf cnt before", 32'(o_cnt[0]), 32'h2);
        iv[0] = 1'b0; rst[0] = 1'b1; flush[0] = 1'b1;
        cyc();
        check("rstf cnt", 32'(o_cnt[0]), 32'h0);
        check("rstf drop", 32'(o_drop[0]), 32'h0);
        check("rstf in_ready low", 32'(o_ready[0]), 32'h0);
        rst[0] = 1'b0; flush[0] = 1'b0;
        #1;
        check("rstf in_ready high", 32'(o_ready[0]), 32'h1);
        cyc();
        check("rstf drop after", 32'(o_drop[0]), 32'h0);

        // Flush with count=2 plus accepted push, DEPTH=3
        ordy[1] = 1'b0; iv[1] = 1'b1; id[1] = 32'h31;
        cyc();
        id[1] = 32'h32;
        cyc();
        check("fl cnt2", 32'(o_cnt[1]), 32'h2);
        check("fl ready", 32'(o_ready[1]), 32'h1);
        id[1] = 32'h33; flush[1] = 1'b1;
        cyc();
        flush[1] = 1'b0; iv[1] = 1'b0;
        check("fl cnt", 32'(o_cnt[1]), 32'h0);
        check("fl out_valid", 32'(o_valid[1]), 32'h0);
        check("fl out_data", o_data[1], NOP);
        check("fl drop", 32'(o_drop[1]), 32'h3);

        // Wrap-around, DEPTH=3, random pops
        k = 0; cycles = 0; max_cnt = 0;
        while (captured.size() < 10 && cycles < 200) begin
            iv[1]   = (k < 10);
            id[1]   = 32'h100 + 32'(k);
            ordy[1] = 1'($urandom_range(0, 1));
            accepted = iv[1] && (mq[1].size() < 3);
            if (o_valid[1] && ordy[1]) captured.push_back(o_data[1]);
            cyc();
            if (accepted) k++;
            if (int'(o_cnt[1]) > max_cnt) max_cnt = int'(o_cnt[1]);
            cycles++;
        end
        iv[1] = 1'b0; ordy[1] = 1'b0;
        check("wrap popped all", 32'(captured.size()), 32'd10);
        for (int j = 0; j < captured.size(); j++)
            check($sformatf("wrap order %0d", j), captured[j], 32'h100 + 32'(j));
        check("wrap max count", 32'(max_cnt <= 3), 32'h1);

        // drop_cnt saturation, DEPTH=2
        for (int f = 0; f < 130; f++) begin
            ordy[0] = 1'b0; iv[0] = 1'b1; id[0] = 32'(f);
            cyc(); cyc();
            iv[0] = 1'b0; flush[0] = 1'b1;
            cyc();
            flush[0] = 1'b0;
            if (f == 99) check("sat drop 200", 32'(o_drop[0]), 32'd200);
        end
        check("sat drop 255", 32'(o_drop[0]), 32'd255);
        iv[0] = 1'b1;
        cyc(); cyc();
        iv[0] = 1'b0; flush[0] = 1'b1;
        cyc();
        flush[0] = 1'b0;
        cyc();
        check("sat drop held", 32'(o_drop[0]), 32'd255);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
